// File: rtl/adc_unmerge_pkg.sv
// Shared constants and types for the merged-word to sample serialiser.
package adc_unmerge_pkg;

  localparam int ADC0_0 = 14;
  localparam int ADC0_1 = 56;
  localparam int SMP_N  = ADC0_1 / ADC0_0;
  localparam int FRM0_0 = 16;
  localparam int SCNT_W = 3;

  typedef logic [ADC0_0-1:0] smp_t;
  typedef logic [ADC0_1-1:0] word_t;
  typedef logic [FRM0_0-1:0] frm_t;
  typedef logic [SCNT_W-1:0] scnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  function automatic frm_t sat_inc(input frm_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adc_unmerge_buf.sv
// One-word hold buffer feeding a sample shift register; owns the load/shift
// decisions so the top only sees emit/load strobes.
module adc_unmerge_buf
  import adc_unmerge_pkg::*;
(
  input  logic  clk250,
  input  logic  rst,
  input  word_t merge_data,
  input  logic  mereg_datv,
  output logic  merge_rdy,
  input  logic  run_i,
  input  logic  words_left_i,
  input  logic  flush_i,
  output logic  emit_o,
  output logic  load_o,
  output logic  last_smp_o,
  output logic  s_empty_o,
  output logic  h_full_o,
  output smp_t  smp_o
);

  logic  h_full_q, h_full_d;
  word_t h_word_q, h_word_d;
  word_t s_word_q, s_word_d;
  scnt_t s_cnt_q, s_cnt_d;
  logic  accept;

  assign merge_rdy  = ~h_full_q;
  assign h_full_o   = h_full_q;
  assign s_empty_o  = (s_cnt_q == 3'd0);
  assign last_smp_o = (s_cnt_q == 3'd1);
  assign smp_o      = s_word_q[ADC0_0-1:0];

  always_comb begin
    accept   = ~h_full_q & mereg_datv;
    emit_o   = run_i & ~flush_i & (s_cnt_q != 3'd0);
    // s_cnt==1 always emits in RUN, so the refill can overlap the final shift
    load_o   = run_i & ~flush_i & h_full_q & words_left_i & (s_cnt_q <= 3'd1);
    h_full_d = h_full_q;
    h_word_d = h_word_q;
    s_word_d = s_word_q;
    s_cnt_d  = s_cnt_q;
    if (flush_i) begin
      h_full_d = 1'b0;
      s_cnt_d  = 3'd0;
    end else begin
      if (emit_o) begin
        s_word_d = s_word_q >> ADC0_0;
        s_cnt_d  = s_cnt_q - 3'd1;
      end
      if (load_o) begin
        s_word_d = h_word_q;
        s_cnt_d  = SCNT_W'(SMP_N);
      end
      if (accept) begin
        h_word_d = merge_data;
        h_full_d = 1'b1;
      end else if (load_o) begin
        h_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      h_full_q <= 1'b0;
      h_word_q <= '0;
      s_word_q <= '0;
      s_cnt_q  <= 3'd0;
    end else begin
      h_full_q <= h_full_d;
      h_word_q <= h_word_d;
      s_word_q <= s_word_d;
      s_cnt_q  <= s_cnt_d;
    end
  end

endmodule

// File: rtl/adc_unmerge.sv
// Replays merged 4-sample words as one sample per clk250, framed by a word count.
//   state | meaning
//   IDLE  | waiting for frm_start; one word may be prefetched into the hold buffer
//   RUN   | frame active; loading words, emitting samples, counting underflow
module adc_unmerge
  import adc_unmerge_pkg::*;
(
  input  logic              clk250,
  input  logic              rst,
  input  logic [ADC0_1-1:0] merge_data,
  input  logic              mereg_datv,
  output logic              merge_rdy,
  input  logic [FRM0_0-1:0] frm_len,
  input  logic              frm_start,
  input  logic              frm_abort,
  output logic [ADC0_0-1:0] adc_data,
  output logic              adc_datv,
  output logic              adc_last,
  output logic              frm_busy,
  output logic [FRM0_0-1:0] undr_cnt
);

  fsm_state_e state_q, state_d;
  frm_t       w_left_q, w_left_d;
  frm_t       undr_q, undr_d;
  smp_t       adc_data_q, adc_data_d;
  logic       adc_datv_q, adc_datv_d;
  logic       adc_last_q, adc_last_d;
  logic       frm_busy_q, frm_busy_d;

  logic emit, load, last_smp, s_empty, h_full, frame_end;
  smp_t smp;

  adc_unmerge_buf u_buf (
    .clk250       (clk250),
    .rst          (rst),
    .merge_data   (merge_data),
    .mereg_datv   (mereg_datv),
    .merge_rdy    (merge_rdy),
    .run_i        (state_q == RUN),
    .words_left_i (w_left_q != '0),
    .flush_i      (frm_abort),
    .emit_o       (emit),
    .load_o       (load),
    .last_smp_o   (last_smp),
    .s_empty_o    (s_empty),
    .h_full_o     (h_full),
    .smp_o        (smp)
  );

  assign adc_data = adc_data_q;
  assign adc_datv = adc_datv_q;
  assign adc_last = adc_last_q;
  assign frm_busy = frm_busy_q;
  assign undr_cnt = undr_q;

  always_comb begin
    state_d    = state_q;
    w_left_d   = w_left_q;
    undr_d     = undr_q;
    adc_data_d = adc_data_q;
    adc_datv_d = 1'b0;
    adc_last_d = 1'b0;
    frm_busy_d = frm_busy_q;
    frame_end  = emit & last_smp & (w_left_q == '0);
    if (frm_abort) begin
      state_d    = IDLE;
      w_left_d   = '0;
      frm_busy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frm_start && (frm_len != '0)) begin
            state_d    = RUN;
            w_left_d   = frm_len;
            undr_d     = '0;
            frm_busy_d = 1'b1;
          end
        end
        RUN: begin
          if (load) w_left_d = w_left_q - 1'b1;
          if (emit) begin
            adc_data_d = smp;
            adc_datv_d = 1'b1;
            adc_last_d = frame_end;
          end
          if (s_empty && !h_full && (w_left_q != '0)) undr_d = sat_inc(undr_q);
          if (frame_end) begin
            state_d    = IDLE;
            frm_busy_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      w_left_q   <= '0;
      undr_q     <= '0;
      adc_data_q <= '0;
      adc_datv_q <= 1'b0;
      adc_last_q <= 1'b0;
      frm_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_left_q   <= w_left_d;
      undr_q     <= undr_d;
      adc_data_q <= adc_data_d;
      adc_datv_q <= adc_datv_d;
      adc_last_q <= adc_last_d;
      frm_busy_q <= frm_busy_d;
    end
  end

endmodule

// File: tb/tb_adc_unmerge.sv
// Scoreboard bench for adc_unmerge: expected samples queued at stimulus time,
// popped and compared by a negedge monitor whenever adc_datv is high.
module tb_adc_unmerge;
  import adc_unmerge_pkg::*;

  logic  clk250 = 1'b0;
  logic  rst;
  word_t merge_data;
  logic  mereg_datv, merge_rdy;
  frm_t  frm_len;
  logic  frm_start, frm_abort;
  smp_t  adc_data;
  logic  adc_datv, adc_last, frm_busy;
  frm_t  undr_cnt;

  adc_unmerge dut (
    .clk250     (clk250),
    .rst        (rst),
    .merge_data (merge_data),
    .mereg_datv (mereg_datv),
    .merge_rdy  (merge_rdy),
    .frm_len    (frm_len),
    .frm_start  (frm_start),
    .frm_abort  (frm_abort),
    .adc_data   (adc_data),
    .adc_datv   (adc_datv),
    .adc_last   (adc_last),
    .frm_busy   (frm_busy),
    .undr_cnt   (undr_cnt)
  );

  always #5 clk250 = ~clk250;

  typedef struct packed {
    logic last;
    smp_t smp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_len = 0;
  int   busy_cnt = 0;
  int   gap_cnt = 0;
  int   last_gaps = -1;
  bit   prev_busy = 1'b0;
  bit   prev_datv = 1'b0;
  int   wt0, wt1, wt2;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic word_t mk_word(input smp_t s0, input smp_t s1, input smp_t s2, input smp_t s3);
    return {s3, s2, s1, s0};
  endfunction

  function automatic word_t rnd_word();
    return word_t'({$urandom(), $urandom()});
  endfunction

  // Reference: a frame is its words' samples, lowest slice first, last flag on the final one.
  task automatic push_frame(input word_t ws[$]);
    for (int i = 0; i < ws.size(); i++)
      for (int k = 0; k < SMP_N; k++) begin
        exp_t e;
        e.smp  = ws[i][k*ADC0_0 +: ADC0_0];
        e.last = (i == ws.size() - 1) && (k == SMP_N - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic send_word(input word_t w, output int waits);
    bit r;
    mereg_datv = 1'b1;
    merge_data = w;
    waits = 0;
    for (int n = 0; n < 100; n++) begin
      r = merge_rdy;
      @(posedge clk250); #1;
      if (r) begin
        mereg_datv = 1'b0;
        return;
      end
      waits++;
    end
    mereg_datv = 1'b0;
    timeout_fail("send_word");
  endtask

  task automatic start_frame(input int len);
    frm_len   = frm_t'(len);
    frm_start = 1'b1;
    cur_len   = len;
    @(posedge clk250); #1;
    frm_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0 && !frm_busy) return;
      @(posedge clk250); #1;
    end
    timeout_fail(name);
  endtask

  // Every RUN edge either emits, loads an empty shift register (first load plus one per
  // stall), or is an underflow; so underflows = busy cycles - samples - 1 - stalls.
  always @(negedge clk250) begin
    if (frm_busy && !prev_busy) begin
      busy_cnt = 0;
      gap_cnt  = 0;
    end else if (frm_busy && !adc_datv && prev_datv) begin
      gap_cnt++;
    end
    if (frm_busy) busy_cnt++;
    if (adc_last && !adc_datv) begin
      checks++;
      errors++;
      $display("FAIL last_without_valid: adc_last=1 adc_datv=0");
    end
    if (adc_datv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got %0h expected none", adc_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("smp_data", 64'(adc_data), 64'(e.smp));
        chk("smp_last", 64'(adc_last), 64'(e.last));
      end
      if (adc_last) begin
        chk("undr_frame", 64'(undr_cnt), 64'(busy_cnt - SMP_N * cur_len - 1 - gap_cnt));
        last_gaps = gap_cnt;
      end
    end
    prev_busy = frm_busy;
    prev_datv = adc_datv;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    word_t wq[$];
    word_t w0, w1, w2;
    rst = 1'b1;
    mereg_datv = 1'b0;
    merge_data = '0;
    frm_len = '0;
    frm_start = 1'b0;
    frm_abort = 1'b0;
    repeat (3) @(posedge clk250);
    #1;
    chk("rst_data", 64'(adc_data), 64'(0));
    chk("rst_datv", 64'(adc_datv), 64'(0));
    chk("rst_last", 64'(adc_last), 64'(0));
    chk("rst_busy", 64'(frm_busy), 64'(0));
    chk("rst_undr", 64'(undr_cnt), 64'(0));
    chk("rst_rdy", 64'(merge_rdy), 64'(1));
    rst = 1'b0;
    @(posedge clk250); #1;

    // prefetch frame, exact latency
    w0 = mk_word(14'h0000, 14'h0001, 14'h0002, 14'h0003);
    wq = {w0};
    push_frame(wq);
    send_word(w0, wt0);
    start_frame(1);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk250); #1;
      chk("t1_datv", 64'(adc_datv), 64'(i >= 2 && i <= 5));
      chk("t1_busy", 64'(frm_busy), 64'(i <= 4));
    end
    wait_done("t1_done");

    // streaming 3-word frame
    w0 = mk_word(14'd0, 14'd1, 14'd2, 14'd3);
    w1 = mk_word(14'd4, 14'd5, 14'd6, 14'd7);
    w2 = mk_word(14'd8, 14'd9, 14'd10, 14'd11);
    wq = {w0, w1, w2};
    push_frame(wq);
    send_word(w0, wt0);
    fork
      start_frame(3);
      begin
        send_word(w1, wt1);
        send_word(w2, wt2);
      end
    join
    wait_done("t2_done");
    chk("t2_wait1", 64'(wt1 <= 3), 64'(1));
    chk("t2_wait2", 64'(wt2 <= 3), 64'(1));
    chk("t2_gaps", 64'(last_gaps), 64'(0));
    chk("t2_undr", 64'(undr_cnt), 64'(0));

    // underflow: second word accepted on the 10th edge after start
    w0 = mk_word(14'h1100, 14'h1101, 14'h1102, 14'h1103);
    w1 = mk_word(14'h2200, 14'h2201, 14'h2202, 14'h2203);
    wq = {w0, w1};
    push_frame(wq);
    send_word(w0, wt0);
    start_frame(2);
    repeat (9) begin
      @(posedge clk250); #1;
    end
    send_word(w1, wt1);
    wait_done("t3_done");
    chk("t3_undr", 64'(undr_cnt), 64'(5));
    chk("t3_gaps", 64'(last_gaps), 64'(1));

    // zero-length start is ignored
    frm_len = '0;
    frm_start = 1'b1;
    @(posedge clk250); #1;
    frm_start = 1'b0;
    chk("t6a_busy", 64'(frm_busy), 64'(0));
    chk("t6a_undr", 64'(undr_cnt), 64'(5));
    @(posedge clk250); #1;
    chk("t6a_busy2", 64'(frm_busy), 64'(0));

    // start during RUN is ignored; frame still ends after 2 words
    w0 = rnd_word();
    w1 = rnd_word();
    wq = {w0, w1};
    push_frame(wq);
    start_frame(2);
    repeat (3) begin
      @(posedge clk250); #1;
    end
    frm_len = frm_t'(5);
    frm_start = 1'b1;
    @(posedge clk250); #1;
    frm_start = 1'b0;
    chk("t6b_busy", 64'(frm_busy), 64'(1));
    chk("t6b_undr", 64'(undr_cnt), 64'(4));
    send_word(w0, wt0);
    send_word(w1, wt1);
    wait_done("t6b_done");

    // abort after two samples while the hold buffer has the next word
    w0 = mk_word(14'h0a00, 14'h0a01, 14'h0a02, 14'h0a03);
    w1 = mk_word(14'h0b00, 14'h0b01, 14'h0b02, 14'h0b03);
    wq = {w0, w1};
    push_frame(wq);
    send_word(w0, wt0);
    fork
      start_frame(2);
      send_word(w1, wt1);
    join
    @(posedge clk250); #1;
    chk("t4_rdy_before", 64'(merge_rdy), 64'(0));
    frm_abort = 1'b1;
    @(posedge clk250); #1;
    frm_abort = 1'b0;
    chk("t4_seen", 64'(exp_q.size()), 64'(6));
    chk("t4_datv", 64'(adc_datv), 64'(0));
    chk("t4_rdy", 64'(merge_rdy), 64'(1));
    chk("t4_busy", 64'(frm_busy), 64'(0));
    exp_q.delete();
    repeat (3) begin
      @(posedge clk250); #1;
    end
    chk("t4_quiet", 64'(adc_datv), 64'(0));
    w0 = mk_word(14'h0c00, 14'h0c01, 14'h0c02, 14'h0c03);
    wq = {w0};
    push_frame(wq);
    send_word(w0, wt0);
    start_frame(1);
    wait_done("t4_replay");

    // asynchronous reset during emission
    w0 = mk_word(14'h3aaa, 14'h2555, 14'h1234, 14'h0fed);
    wq = {w0};
    push_frame(wq);
    send_word(w0, wt0);
    start_frame(1);
    @(posedge clk250); #1;
    @(posedge clk250); #1;
    chk("t5_pre_datv", 64'(adc_datv), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("t5_data", 64'(adc_data), 64'(0));
    chk("t5_datv", 64'(adc_datv), 64'(0));
    chk("t5_last", 64'(adc_last), 64'(0));
    chk("t5_busy", 64'(frm_busy), 64'(0));
    exp_q.delete();
    @(posedge clk250); #1;
    rst = 1'b0;
    chk("t5_rdy", 64'(merge_rdy), 64'(1));
    @(posedge clk250); #1;
    chk("t5_idle", 64'(frm_busy), 64'(0));

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int len;
      bit pre;
      len = int'($urandom_range(1, 4));
      pre = 1'($urandom_range(0, 1));
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(rnd_word());
      push_frame(wq);
      if (pre) send_word(wq[0], wt0);
      fork
        start_frame(len);
        begin
          for (int i = (pre ? 1 : 0); i < len; i++) begin
            repeat ($urandom_range(0, 6)) begin
              @(posedge clk250); #1;
            end
            send_word(wq[i], wt1);
          end
        end
      join
      wait_done("rand_done");
    end

    repeat (2) begin
      @(posedge clk250); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_unmerge.md
Name: adc_unmerge

Overview:
- Replay/transmit direction of the ADC capture path.
- Accepts 56-bit merged words (four 14-bit samples per word) through a valid/ready handshake and serialises them back into one 14-bit sample per clk250 cycle.
- Frames the output stream with a programmable word count.
- Sits between capture memory readout and the DAC/loopback/self-test path, so the downstream logic sees the same sample stream the ADC side produced.

Parameters:
- ADC0_0, 14, sample width in bits.
- ADC0_1, 56, merged word width; must equal 4*ADC0_0. Derived localparam SMP_N = ADC0_1/ADC0_0 = 4.
- FRM0_0, 16, width of the frame length (in words) and of the underflow counter.

Ports:
- clk250  input  1  sample clock; all logic runs in this domain.
- rst  input  1  reset, active-high, asynchronous assert.
- merge_data  input  ADC0_1  merged word; sample k is in bits [k*ADC0_0 +: ADC0_0], and sample 0 is emitted first.
- mereg_datv  input  1  merge_data valid.
- merge_rdy  output  1  block can accept a word this cycle.
- frm_len  input  FRM0_0  frame length in words, sampled on frm_start.
- frm_start  input  1  single-cycle pulse that starts a frame.
- frm_abort  input  1  single-cycle pulse that aborts the frame and flushes buffers.
- adc_data  output  ADC0_0  serialised sample (registered).
- adc_datv  output  1  adc_data valid (registered).
- adc_last  output  1  high with the final sample of a frame.
- frm_busy  output  1  high while the FSM is in RUN.
- undr_cnt  output  FRM0_0  underflow cycle count; saturates at all-ones and clears on frm_start.

Behaviour:
- Connectivity: single clock, clk250. rst is asynchronous, active-high.
- Reset values: adc_data=0, adc_datv=0, adc_last=0, frm_busy=0, undr_cnt=0. Hold buffer H and shift register S are empty, and the FSM is in IDLE.
- Storage:
  - Hold buffer H: one word, flag h_full.
  - Shift register S: one word, sample count s_cnt in 0..4.
  - Word-remaining counter w_left.
- Input handshake:
  - merge_rdy = ~h_full, registered-state driven with no combinational path from mereg_datv.
  - A word is accepted when merge_rdy & mereg_datv; H takes the word.
  - Acceptance is allowed in IDLE (one-word prefetch) and in RUN.
- FSM IDLE:
  - frm_start with frm_len != 0: latch w_left=frm_len, clear undr_cnt, go to RUN.
  - frm_start with frm_len == 0: ignored; stay in IDLE and leave undr_cnt unchanged.
- FSM RUN:
  - Load S: on an edge where h_full and (s_cnt==0, or s_cnt==1 and a sample is emitted this edge), S<=H, s_cnt<=4, w_left decrements, and h_full clears unless a new word is accepted the same edge (simultaneous accept + transfer is legal).
  - Emission: on each edge with s_cnt>0, adc_data<=S[0 +: ADC0_0], S shifts right by ADC0_0, s_cnt decrements, adc_datv<=1. Otherwise adc_datv<=0.
  - Last sample: adc_last<=1 with the emission where s_cnt==1 and w_left==0. The same edge moves the FSM to IDLE and sets frm_busy<=0.
  - Underflow: an edge in RUN with s_cnt==0, ~h_full and w_left>0 increments undr_cnt, saturating.
  - frm_start while in RUN is ignored.
- Latency:
  - frm_start is sampled on edge E0. S loads on E1 if H was prefetched. The first adc_datv is high after E2.
  - Words arriving at least every 4 cycles give a gap-free stream.
- frm_abort (any state): next edge clears h_full, s_cnt, w_left, adc_datv and adc_last, and returns the FSM to IDLE. A word offered on the same edge is dropped. frm_abort has priority over frm_start.
- Reset mid-frame: all state returns immediately to reset values. Any partially emitted word is discarded.

Decomposition:
- Shared package holds:
  - ADC0_0/ADC0_1/SMP_N constants.
  - FSM state enum {IDLE, RUN}.
  - FRM0_0 width.
- One natural sub-module: adc_unmerge_buf, which owns H + S + s_cnt and the load/shift control.
- The top-level adc_unmerge keeps the FSM, w_left, undr_cnt and output registers.

Test Plan:
1. Prefetch frame.
   - Stimulus: W0={14'h0003,14'h0002,14'h0001,14'h0000} accepted in IDLE, then frm_start, frm_len=1.
   - Required response: adc_datv high on 4 consecutive cycles starting 2 cycles after frm_start, carrying 0,1,2,3; adc_last high only with 3; frm_busy falls the same edge.
2. Streaming, 3-word frame.
   - Stimulus: words presented every 4 cycles, with W1 samples 4..7 and W2 samples 8..11.
   - Required response: 12 contiguous samples 0..11 with no adc_datv gap; undr_cnt=0; merge_rdy never low while mereg_datv pends for more than 3 cycles.
3. Underflow.
   - Stimulus: frm_len=2, W1 delayed 6 cycles after W0 is loaded into S.
   - Required response: adc_datv low for the gap cycles; undr_cnt equals the number of low cycles with w_left>0; all 8 samples arrive in order.
4. Abort mid-frame.
   - Stimulus: frm_abort after 2 samples of W0 while H holds W1.
   - Required response: next cycle adc_datv=0, merge_rdy=1, frm_busy=0; a new frame replays from a freshly supplied word.
5. Async reset mid-frame.
   - Stimulus: assert rst between clock edges during emission.
   - Required response: outputs go to 0 without waiting for a clock edge; merge_rdy=1 after release.
6. Ignored start.
   - Stimulus: frm_start with frm_len=0; separately, frm_start during RUN.
   - Required response: no state change and undr_cnt unchanged in both cases; the running frame completes normally.
